// File: rtl/sram_like_arbiter_pkg.sv
// Shared master IDs, size encodings and request bundle for the inst/data SRAM-like arbiter.
// Pure declarations: no latency, no backpressure of their own.
package sram_like_arbiter_pkg;

   localparam logic MID_INST = 1'b0;
   localparam logic MID_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of master IDs for accepted requests; push and pop each take effect at the next clock edge.
// Full/empty come from the registered count; push when full and pop when empty are dropped.
module sram_arb_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         // push+pop together leaves the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the inst and data channels; addr_ok/data_ok pass through combinationally.
// A stalled request is locked until accepted; new requests stall while OUTSTANDING responses are pending.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int STARVE_MAX  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   sram_req_t   inst_bus;
   sram_req_t   data_bus;
   sram_req_t   gnt_bus;
   logic        grant;
   logic        gnt_req;
   logic        starved;
   logic        hs;
   logic        pop;
   logic        lock_vld;
   logic        lock_id;
   logic [SW-1:0] starve_cnt;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_head;

   assign inst_bus = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
   assign data_bus = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

   assign starved = (starve_cnt == SW'(STARVE_MAX)) && inst_req;

   // a locked request keeps the port so the presented fields never change before acceptance
   always_comb begin
      grant = MID_INST;
      if (lock_vld)      grant = lock_id;
      else if (starved)  grant = MID_INST;
      else if (data_req) grant = MID_DATA;
   end

   assign gnt_req = (grant == MID_DATA) ? data_req : inst_req;
   assign gnt_bus = (grant == MID_DATA) ? data_bus : inst_bus;

   assign mem_req   = resetn & ~fifo_full & gnt_req;
   assign mem_wr    = gnt_bus.wr;
   assign mem_size  = gnt_bus.size;
   assign mem_wstrb = gnt_bus.wstrb;
   assign mem_addr  = gnt_bus.addr;
   assign mem_wdata = gnt_bus.wdata;

   assign hs           = mem_req & mem_addr_ok;
   assign inst_addr_ok = hs & (grant == MID_INST);
   assign data_addr_ok = hs & (grant == MID_DATA);

   assign pop          = mem_data_ok & ~fifo_empty;
   assign inst_data_ok = pop & (fifo_head == MID_INST);
   assign data_data_ok = pop & (fifo_head == MID_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vld <= 1'b0;
         lock_id  <= MID_INST;
      end else if (mem_req & ~mem_addr_ok) begin
         lock_vld <= 1'b1;
         lock_id  <= grant;
      end else if (hs) begin
         lock_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!inst_req || (hs && grant == MID_INST)) begin
         starve_cnt <= '0;
      end else if (grant == MID_DATA && starve_cnt != SW'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   sram_arb_id_fifo #(
      .WIDTH (1),
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (hs),
      .push_dat (grant),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

endmodule
